// File: rtl/frame_receiver_with_error_check_if.sv
// Bundles the byte stream, golden frame and per-frame status of the frame receiver.
// The master side drives bytes and the golden frame; the slave side returns status.
interface frame_receiver_with_error_check_if;
    logic [7:0]   frame_data;
    logic         valid;
    logic [127:0] expected_frame;
    logic         frame_done;
    logic         frame_ok;
    logic         error_detected;
    logic [4:0]   error_count;
    logic [3:0]   first_error_index;
    logic [7:0]   first_error_mask;
    logic [15:0]  frames_received;
    logic [15:0]  frames_bad;
    logic         rx_busy;
    logic         timeout_abort;

    modport master (
        output frame_data, valid, expected_frame,
        input  frame_done, frame_ok, error_detected, error_count, first_error_index,
               first_error_mask, frames_received, frames_bad, rx_busy, timeout_abort
    );

    modport slave (
        input  frame_data, valid, expected_frame,
        output frame_done, frame_ok, error_detected, error_count, first_error_index,
               first_error_mask, frames_received, frames_bad, rx_busy, timeout_abort
    );
endinterface

// File: rtl/frame_receiver_with_error_check.sv
// Receives 16-byte frames, compares each byte against a golden frame latched at byte 0,
// and reports per-frame mismatch status; partial frames are dropped after an idle timeout.
module frame_receiver_with_error_check #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input logic                              clk,
    input logic                              reset,
    frame_receiver_with_error_check_if.slave bus
);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StReceive, StReport} state_e;

    state_e state_q, state_d;

    logic [IdleW-1:0] idle_q, idle_d;
    logic [3:0]       idx_q, idx_d;
    logic [127:0]     exp_q, exp_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       fidx_q, fidx_d;
    logic [7:0]       fmask_q, fmask_d;

    logic        done_q, done_d, ok_q, ok_d, err_q, err_d, busy_q, busy_d, tmo_q, tmo_d;
    logic [4:0]  ecnt_q, ecnt_d;
    logic [3:0]  eidx_q, eidx_d;
    logic [7:0]  emask_q, emask_d;
    logic [15:0] frx_q, frx_d, fbad_q, fbad_d;

    logic       receiving, last_byte, timeout_hit, mismatch;
    logic [3:0] cur_idx;
    logic [7:0] exp_byte, diff;
    logic [4:0] base_cnt, new_cnt;
    logic [3:0] new_fidx;
    logic [7:0] new_fmask;

    // Byte 0 is compared against the live golden input since it is latched on that same edge.
    always_comb begin
        receiving   = (state_q == StReceive);
        cur_idx     = receiving ? idx_q : 4'd0;
        exp_byte    = receiving ? exp_q[{cur_idx, 3'b000} +: 8] : bus.expected_frame[7:0];
        diff        = bus.frame_data ^ exp_byte;
        mismatch    = |diff;
        base_cnt    = receiving ? cnt_q : 5'd0;
        new_cnt     = base_cnt + {4'd0, mismatch};
        new_fidx    = receiving ? fidx_q : 4'd0;
        new_fmask   = receiving ? fmask_q : 8'd0;
        if (mismatch && (base_cnt == 5'd0)) begin
            new_fidx  = cur_idx;
            new_fmask = diff;
        end
        last_byte   = receiving && bus.valid && (idx_q == 4'd15);
        timeout_hit = receiving && !bus.valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StReport: state_d = bus.valid ? StReceive : StIdle;
            StReceive: begin
                if (last_byte) begin
                    state_d = StReport;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        fidx_d  = fidx_q;
        fmask_d = fmask_q;
        idle_d  = '0;
        if (bus.valid) begin
            idx_d   = cur_idx + 4'd1;
            cnt_d   = new_cnt;
            fidx_d  = new_fidx;
            fmask_d = new_fmask;
            if (!receiving) begin
                exp_d = bus.expected_frame;
            end
        end else if (receiving && !timeout_hit) begin
            idle_d = idle_q + IdleW'(1);
        end
        if (timeout_hit) begin
            idx_d = 4'd0;
        end

        done_d  = last_byte;
        tmo_d   = timeout_hit;
        busy_d  = (state_d == StReceive);
        ok_d    = ok_q;
        err_d   = err_q;
        ecnt_d  = ecnt_q;
        eidx_d  = eidx_q;
        emask_d = emask_q;
        frx_d   = frx_q;
        fbad_d  = fbad_q;
        if (last_byte) begin
            ok_d    = (new_cnt == 5'd0);
            err_d   = (new_cnt != 5'd0);
            ecnt_d  = new_cnt;
            eidx_d  = new_fidx;
            emask_d = new_fmask;
            frx_d   = frx_q + 16'd1;
            fbad_d  = fbad_q + {15'd0, (new_cnt != 5'd0)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q  <= '0;
            idx_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            fidx_q  <= '0;
            fmask_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ecnt_q  <= '0;
            eidx_q  <= '0;
            emask_q <= '0;
            frx_q   <= '0;
            fbad_q  <= '0;
        end else begin
            idle_q  <= idle_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            fidx_q  <= fidx_d;
            fmask_q <= fmask_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            ecnt_q  <= ecnt_d;
            eidx_q  <= eidx_d;
            emask_q <= emask_d;
            frx_q   <= frx_d;
            fbad_q  <= fbad_d;
        end
    end

    assign bus.frame_done        = done_q;
    assign bus.frame_ok          = ok_q;
    assign bus.error_detected    = err_q;
    assign bus.error_count       = ecnt_q;
    assign bus.first_error_index = eidx_q;
    assign bus.first_error_mask  = emask_q;
    assign bus.frames_received   = frx_q;
    assign bus.frames_bad        = fbad_q;
    assign bus.rx_busy           = busy_q;
    assign bus.timeout_abort     = tmo_q;
endmodule

// File: tb/tb_frame_receiver_with_error_check.sv
// Directed, table-driven bench for frame_receiver_with_error_check.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_frame_receiver_with_error_check;
    logic clk = 1'b0;
    logic reset = 1'b1;

    frame_receiver_with_error_check_if bus_if ();

    frame_receiver_with_error_check #(.TIMEOUT_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] rx;
        logic [127:0] exp;
        logic [4:0]   cnt;
        logic [3:0]   idx;
        logic [7:0]   mask;
    } vec_t;

    localparam logic [127:0] Golden = 128'h0A090807060504030201FFEEDDCCBBAA;

    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;
    int   tmo_seen = 0;
    int   model_rx = 0;
    int   model_bad = 0;

    always @(negedge clk) begin
        if (bus_if.frame_done) done_seen++;
        if (bus_if.timeout_abort) tmo_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents bytes lo..hi on consecutive cycles; the golden input is scrambled after byte 0.
    task automatic send_bytes(input logic [127:0] rx, input logic [127:0] exp,
                              input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            bus_if.valid          = 1'b1;
            bus_if.frame_data     = rx[8*k +: 8];
            bus_if.expected_frame = (k == 0) ? exp : ~exp;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        bus_if.valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus_if.frame_done, bus_if.frame_ok, bus_if.error_detected,
                     bus_if.error_count, bus_if.first_error_index, bus_if.rx_busy,
                     bus_if.timeout_abort}, 32'd0);
        check({name, "_mask"}, {24'd0, bus_if.first_error_mask}, 32'd0);
        check({name, "_ctrs"}, {bus_if.frames_received, bus_if.frames_bad}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.valid = 1'b1;
        bus_if.frame_data = 8'h5A;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_if.valid = 1'b0;
        model_rx = 0;
        model_bad = 0;
    endtask

    task automatic check_report(input string name, input logic [4:0] cnt,
                                input logic [3:0] idx, input logic [7:0] mask);
        model_rx++;
        if (cnt != 0) model_bad++;
        check({name, "_done"}, {31'd0, bus_if.frame_done}, 32'd1);
        check({name, "_ok_err"}, {30'd0, bus_if.frame_ok, bus_if.error_detected},
              (cnt == 0) ? 32'd2 : 32'd1);
        check({name, "_count"}, {27'd0, bus_if.error_count}, {27'd0, cnt});
        check({name, "_index"}, {28'd0, bus_if.first_error_index}, {28'd0, idx});
        check({name, "_mask"}, {24'd0, bus_if.first_error_mask}, {24'd0, mask});
        check({name, "_rx"}, {16'd0, bus_if.frames_received}, model_rx);
        check({name, "_bad"}, {16'd0, bus_if.frames_bad}, model_bad);
    endtask

    initial begin
        int d0;
        int t0;
        vecs[0] = '{Golden, Golden, 5'd0, 4'd0, 8'h00};
        vecs[1] = '{128'h0A090807060504030201FFFEDDCCBBAA, Golden, 5'd1, 4'd4, 8'h10};
        vecs[2] = '{128'h0A090807060584030201FFEEDDCDBBAA, Golden, 5'd2, 4'd2, 8'h01};
        vecs[3] = '{128'h0, Golden, 5'd16, 4'd0, 8'hAA};
        vecs[4] = '{128'h8A090807060504030201FFEEDDCCBBAA, Golden, 5'd1, 4'd15, 8'h80};
        vecs[5] = '{{16{8'h55}}, {16{8'h55}}, 5'd0, 4'd0, 8'h00};

        bus_if.valid = 1'b0;
        bus_if.frame_data = 8'h00;
        bus_if.expected_frame = '0;
        #1;
        do_reset();
        check_all_zero("reset");

        for (int v = 0; v < 6; v++) begin
            send_bytes(vecs[v].rx, vecs[v].exp, 0, 15);
            bus_if.valid = 1'b0;
            check_report($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].idx, vecs[v].mask);
            idle_cycles(1);
            check($sformatf("vec%0d_pulse", v), {31'd0, bus_if.frame_done}, 32'd0);
        end
        check("vec_status_hold", {27'd0, bus_if.error_count}, 32'd0);

        // Short gap mid-frame must not disturb the result.
        t0 = tmo_seen;
        send_bytes(vecs[2].rx, Golden, 0, 7);
        idle_cycles(10);
        check("gap_busy", {31'd0, bus_if.rx_busy}, 32'd1);
        send_bytes(vecs[2].rx, Golden, 8, 15);
        bus_if.valid = 1'b0;
        check_report("gap", 5'd2, 4'd2, 8'h01);
        check("gap_no_timeout", tmo_seen - t0, 32'd0);
        idle_cycles(1);

        // Timeout: abort exactly after 32 idle cycles, status untouched.
        do_reset();
        d0 = done_seen;
        send_bytes(vecs[1].rx, Golden, 0, 7);
        idle_cycles(31);
        check("tmo_not_yet", {30'd0, bus_if.timeout_abort, bus_if.rx_busy}, 32'd1);
        idle_cycles(1);
        check("tmo_pulse", {30'd0, bus_if.timeout_abort, bus_if.rx_busy}, 32'd2);
        idle_cycles(1);
        check("tmo_pulse_end", {31'd0, bus_if.timeout_abort}, 32'd0);
        check("tmo_no_done", done_seen - d0, 32'd0);
        check("tmo_status", {bus_if.frames_received, 11'd0, bus_if.error_count}, 32'd0);
        send_bytes(Golden, Golden, 0, 15);
        bus_if.valid = 1'b0;
        check_report("after_tmo", 5'd0, 4'd0, 8'h00);
        idle_cycles(1);

        // Back-to-back frames, then reset in the middle of a third.
        do_reset();
        d0 = done_seen;
        t0 = tmo_seen;
        send_bytes(Golden, Golden, 0, 15);
        check("b2b_first_done", {31'd0, bus_if.frame_done}, 32'd1);
        model_rx++;
        send_bytes(vecs[1].rx, Golden, 0, 15);
        check_report("b2b_second", 5'd1, 4'd4, 8'h10);
        send_bytes(Golden, Golden, 0, 4);
        check("b2b_busy", {31'd0, bus_if.rx_busy}, 32'd1);
        do_reset();
        check_all_zero("mid_reset");
        idle_cycles(40);
        check("b2b_done_pulses", done_seen - d0, 32'd2);
        check("reset_no_timeout", tmo_seen - t0, 32'd0);
        check_all_zero("post_reset_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
